// File: rtl/sap_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg
// Shared constants for the SAP bus and its sources/destinations.
//   DATA_W         width of the shared bus and of every word carried on it
//   BUS_IDLE       value a bus source drives while it is not selected, so that
//                  all sources can be OR-merged onto one bus
//   IN_PORT_DEPTH  default number of words buffered by the input port
// -----------------------------------------------------------------------------
package sap_pkg;

   localparam int DATA_W = 16;

   localparam logic [DATA_W-1:0] BUS_IDLE = 16'h0000;

   localparam int IN_PORT_DEPTH = 4;

endpackage

// File: rtl/sap_fifo.sv
// -----------------------------------------------------------------------------
// sap_fifo
// Small synchronous FIFO with combinational head-of-queue read-out.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset of pointers and count
//   i_push       write i_pushData at the tail (ignored while full)
//   i_pushData   word to write
//   i_pop        drop the head word (ignored while empty)
//   o_headData   word at the head of the queue (undefined while empty)
//   o_count      number of stored words, 0..DEPTH
//   o_empty      o_count == 0
//   o_full       o_count == DEPTH
// -----------------------------------------------------------------------------
module sap_fifo
   import sap_pkg::*;
#(
   parameter int DATA_W = sap_pkg::DATA_W,
   parameter int DEPTH  = sap_pkg::IN_PORT_DEPTH,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_pushData,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_headData,
   output logic [PTR_W:0]    o_count,
   output logic              o_empty,
   output logic              o_full
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [PTR_W:0]    r_count;
   logic              w_push;
   logic              w_pop;

   // Guard the strobes here as well so the FIFO can never overrun or
   // underrun, whatever the caller does.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   assign o_count    = r_count;
   assign o_empty    = (r_count == '0);
   assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
   assign o_headData = r_mem[r_rdPtr];

   // Storage is deliberately left out of reset: the pointers and count alone
   // decide which entries are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   // Pointers are exactly PTR_W bits wide, so with DEPTH a power of two they
   // wrap modulo DEPTH on their own. The count moves only when exactly one of
   // push/pop happens; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/bus_input_port.sv
// -----------------------------------------------------------------------------
// bus_input_port
// Source-side partner of the SAP bus-loaded registers. Buffers words from an
// external producer (valid/ready) and puts the head word on the shared bus in
// the same cycle the controller strobes in_read, popping it at that edge.
// The bus output is zero while not driving so it can be OR-merged.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   ext_valid  producer has a word on ext_data
//   ext_data   producer word
//   ext_ready  port can accept a word this cycle (not full)
//   in_read    controller strobe: drive head word and pop it
//   clr_err    synchronous clear of the sticky underflow flag
//   bus_out    head word while driving, otherwise BUS_IDLE
//   bus_drive  port is driving the bus this cycle
//   empty      no words stored
//   full       DEPTH words stored
//   count      number of stored words
//   underflow  sticky: in_read was seen while empty
// -----------------------------------------------------------------------------
module bus_input_port
   import sap_pkg::*;
#(
   parameter int DATA_W = sap_pkg::DATA_W,
   parameter int DEPTH  = sap_pkg::IN_PORT_DEPTH,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ext_valid,
   input  logic [DATA_W-1:0] ext_data,
   output logic              ext_ready,
   input  logic              in_read,
   input  logic              clr_err,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_drive,
   output logic              empty,
   output logic              full,
   output logic [PTR_W:0]    count,
   output logic              underflow
);

   logic              w_push;
   logic              w_empty;
   logic              w_full;
   logic [DATA_W-1:0] w_head;
   logic [PTR_W:0]    w_count;
   logic              r_underflow;

   sap_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_pushData (ext_data),
      .i_pop      (bus_drive),
      .o_headData (w_head),
      .o_count    (w_count),
      .o_empty    (w_empty),
      .o_full     (w_full)
   );

   // Push and drive decisions both use the pre-edge occupancy. That means a
   // read on an empty FIFO never bypasses an incoming word, and a full FIFO
   // refuses the producer even while it is being read.
   assign ext_ready = !w_full;
   assign w_push    = ext_valid && ext_ready;
   assign bus_drive = in_read && !w_empty;
   assign bus_out   = bus_drive ? w_head : DATA_W'(BUS_IDLE);

   assign empty     = w_empty;
   assign full      = w_full;
   assign count     = w_count;
   assign underflow = r_underflow;

   // Sticky underflow flag. A fresh underflow takes priority over a clear
   // request in the same cycle so an error is never silently lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_underflow <= 1'b0;
      end else if (in_read && w_empty) begin
         r_underflow <= 1'b1;
      end else if (clr_err) begin
         r_underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_input_port.sv
// -----------------------------------------------------------------------------
// tb_bus_input_port
// Self-checking bench for bus_input_port: a queue-based reference model is
// compared against every output once per cycle, directed sequences pin
// specific literal values, and a randomized phase exercises mixed traffic.
// -----------------------------------------------------------------------------
module tb_bus_input_port;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int PTR_W  = 2;

   logic              clk       = 1'b0;
   logic              rst       = 1'b1;
   logic              ext_valid = 1'b0;
   logic [DATA_W-1:0] ext_data  = '0;
   logic              in_read   = 1'b0;
   logic              clr_err   = 1'b0;
   logic              ext_ready;
   logic [DATA_W-1:0] bus_out;
   logic              bus_drive;
   logic              empty;
   logic              full;
   logic [PTR_W:0]    count;
   logic              underflow;

   int nVectors     = 0;
   int nMiscompares = 0;
   bit checkOn      = 1'b0;

   logic [DATA_W-1:0] modelQ [$];
   bit                modelUf = 1'b0;

   bus_input_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ext_valid (ext_valid),
      .ext_data  (ext_data),
      .ext_ready (ext_ready),
      .in_read   (in_read),
      .clr_err   (clr_err),
      .bus_out   (bus_out),
      .bus_drive (bus_drive),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .underflow (underflow)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // One comparison: counts it, and reports a miscompare with both values.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs just after the falling edge, then give the
   // combinational outputs time to settle before the caller inspects them.
   task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                input logic rd, input logic clr);
      @(negedge clk);
      ext_valid = v;
      ext_data  = d;
      in_read   = rd;
      clr_err   = clr;
      #2;
   endtask

   // Assert reset between clock edges and confirm the outputs collapse to
   // their reset values before the next rising edge arrives.
   task automatic resetDut();
      @(negedge clk);
      ext_valid = 1'b0;
      in_read   = 1'b0;
      clr_err   = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      checkOutput("rst_empty",     empty,     1);
      checkOutput("rst_full",      full,      0);
      checkOutput("rst_count",     count,     0);
      checkOutput("rst_ext_ready", ext_ready, 1);
      checkOutput("rst_bus_drive", bus_drive, 0);
      checkOutput("rst_bus_out",   bus_out,   0);
      checkOutput("rst_underflow", underflow, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reference model and per-cycle comparison. Expected outputs come from the
   // queue contents and the current inputs; the queue is advanced at each
   // rising edge from the same pre-edge occupancy the port is defined on.
   always begin : compareProc
      int                sz;
      logic              expDrive;
      logic [DATA_W-1:0] expBus;
      bit                doPop;
      bit                doPush;
      @(negedge clk);
      #1;
      if (checkOn) begin
         sz       = modelQ.size();
         expDrive = in_read && (sz > 0);
         expBus   = expDrive ? modelQ[0] : '0;
         checkOutput("model_ext_ready", ext_ready, (sz < DEPTH));
         checkOutput("model_bus_drive", bus_drive, expDrive);
         checkOutput("model_bus_out",   bus_out,   expBus);
         checkOutput("model_empty",     empty,     (sz == 0));
         checkOutput("model_full",      full,      (sz == DEPTH));
         checkOutput("model_count",     count,     sz);
         checkOutput("model_underflow", underflow, modelUf);
      end
      @(posedge clk);
      if (rst) begin
         modelQ.delete();
         modelUf = 1'b0;
      end else begin
         doPop  = in_read && (modelQ.size() > 0);
         doPush = ext_valid && (modelQ.size() < DEPTH);
         if (in_read && (modelQ.size() == 0)) begin
            modelUf = 1'b1;
         end else if (clr_err) begin
            modelUf = 1'b0;
         end
         if (doPop) begin
            void'(modelQ.pop_front());
         end
         if (doPush) begin
            modelQ.push_back(ext_data);
         end
      end
   end

   // Safety net in case the stimulus ever stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequences followed by randomized traffic.
   initial begin
      int pv;
      int pr;
      repeat (2) @(negedge clk);
      rst     = 1'b0;
      checkOn = 1'b1;

      resetDut();

      // Fill and drain in order.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 16'(16'h1111 * (i + 1)), 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("fill_full",      full,      1);
      checkOutput("fill_ext_ready", ext_ready, 0);
      checkOutput("fill_count",     count,     4);
      applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
      checkOutput("full_refuse", ext_ready, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
         checkOutput("drain_drive", bus_drive, 1);
         checkOutput("drain_bus",   bus_out,   16'(16'h1111 * (i + 1)));
      end
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("drain_empty", empty,     1);
      checkOutput("drain_uf",    underflow, 0);

      // Wrap-around of both pointers.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(16'hA000 + i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
         checkOutput("wrap_bus_a", bus_out, 16'(16'hA000 + i));
      end
      for (int i = 3; i < 7; i++) applyStimulus(1'b1, 16'(16'hA000 + i), 1'b0, 1'b0);
      for (int i = 3; i < 7; i++) begin
         applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
         checkOutput("wrap_bus_b", bus_out, 16'(16'hA000 + i));
      end
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("wrap_count", count,     0);
      checkOutput("wrap_uf",    underflow, 0);

      // Simultaneous push and pop holds the count.
      applyStimulus(1'b1, 16'hB000, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'hB001, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 16'(16'hB002 + i), 1'b1, 1'b0);
         checkOutput("simul_count", count,   2);
         checkOutput("simul_bus",   bus_out, 16'(16'hB000 + i));
      end
      applyStimulus(1'b1, 16'hC000, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'hC001, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'hC002, 1'b1, 1'b0);
      checkOutput("fullrd_bus",   bus_out,   16'hB005);
      checkOutput("fullrd_ready", ext_ready, 0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("fullrd_count", count, 3);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("tail_bus0", bus_out, 16'hB006);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("tail_bus1", bus_out, 16'hC000);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("tail_bus2", bus_out, 16'hC001);

      // Underflow set, hold, clear, and set-wins-over-clear.
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("uf_drive",  bus_drive, 0);
      checkOutput("uf_bus",    bus_out,   0);
      checkOutput("uf_before", underflow, 0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("uf_set",  underflow, 1);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
      checkOutput("uf_held", underflow, 1);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("uf_clr",  underflow, 0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("uf_set_wins", underflow, 1);

      // Empty with push and read together: push only, no bypass.
      applyStimulus(1'b1, 16'hD000, 1'b1, 1'b0);
      checkOutput("nobypass_drive", bus_drive, 0);
      checkOutput("nobypass_bus",   bus_out,   0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("nobypass_count", count,     1);
      checkOutput("nobypass_uf",    underflow, 1);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
      checkOutput("nobypass_pop", bus_out, 16'hD000);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("nobypass_clr", underflow, 0);

      // Reset mid-stream discards stored words.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(16'hE000 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("mid_count", count, 3);
      resetDut();
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("post_rst_drive", bus_drive, 0);
      checkOutput("post_rst_bus",   bus_out,   0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("post_rst_uf", underflow, 1);

      // Randomized traffic, alternating between producer-heavy and
      // reader-heavy phases so both full and empty are visited often.
      for (int phase = 0; phase < 4; phase++) begin
         pv = (phase % 2 == 0) ? 75 : 30;
         pr = (phase % 2 == 0) ? 30 : 75;
         for (int i = 0; i < 100; i++) begin
            applyStimulus(($urandom_range(0, 99) < pv), 16'($urandom),
                          ($urandom_range(0, 99) < pr), ($urandom_range(0, 15) == 0));
         end
      end

      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/bus_input_port.md
Name: bus_input_port

Overview:
- Source-side partner of the SAP bus-loaded registers: accepts words from an external producer and places them on the shared 16-bit bus when the controller asks for an input transfer.
- Buffers up to DEPTH words in a FIFO.
- Drives the bus with a combinational, zero-when-idle output, so it can be OR-merged with the other bus sources. On the same edge, any destination register with its write strobe asserted captures the word.

Parameters:
- DATA_W, 16, bus and word width.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ext_valid  in  1  external producer has a word.
- ext_data  in  DATA_W  external word.
- ext_ready  out  1  port can accept a word this cycle.
- in_read  in  1  controller strobe: drive the head word onto the bus this cycle and pop it.
- clr_err  in  1  synchronous clear of the sticky underflow flag.
- bus_out  out  DATA_W  head word while driving, otherwise 0.
- bus_drive  out  1  port is driving the bus this cycle.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  PTR_W+1  number of stored words, 0..DEPTH.
- underflow  out  1  sticky: in_read was asserted while the FIFO was empty.

Behaviour:
- Reset (asynchronous, active-high, clk and rst only):
  - Read/write pointers, count and underflow go to 0; storage array is not reset.
  - Resulting outputs: empty=1, full=0, ext_ready=1, bus_drive=0, bus_out=0.
  - Reset asserted mid-operation discards all stored words immediately.
- Push:
  - ext_ready = !full, combinational from count.
  - On a rising edge with ext_valid && ext_ready, ext_data is written at wr_ptr and wr_ptr increments.
- Pop / drive:
  - bus_drive = in_read && !empty (combinational).
  - bus_out = mem[rd_ptr] when bus_drive, else 0.
  - On a rising edge with bus_drive, rd_ptr increments. Latency: the word is on the bus in the same cycle as in_read.
- Pointers wrap modulo DEPTH.
- count: +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop.
- Boundary conditions:
  - Full and in_read: pop occurs; ext_ready is 0 that cycle, so there is no push and no pass-through.
  - Empty with ext_valid and in_read together:
    - push occurs, no bypass;
    - bus_drive=0 and bus_out=0;
    - underflow sets at the edge;
    - count becomes 1.
  - Underflow: in_read && empty sets underflow at the next edge. It is held until clr_err is sampled or reset. If clr_err and a new underflow occur in the same cycle, set wins.
  - ext_valid while full: the word is not accepted; the producer must hold it (valid/ready protocol).
  - ext_data is sampled only when ext_valid && ext_ready.
  - Back-to-back in_read strobes pop consecutive words in FIFO order.
- No other internal state and no state machine beyond the FIFO occupancy.

Decomposition:
- Shared package sap_pkg:
  - DATA_W = 16;
  - BUS_IDLE = 16'h0000;
  - default input-port depth constant IN_PORT_DEPTH = 4.
- One natural sub-module, sap_fifo:
  - parameterised DATA_W/DEPTH;
  - push/pop/count/empty/full;
  - asynchronous active-high reset of pointers and count.
- bus_input_port wraps sap_fifo and adds the bus drive gating and the underflow flag.

Test Plan:
- Reset check: assert rst asynchronously between edges -> empty=1, count=0, ext_ready=1, bus_drive=0, bus_out=0, underflow=0 immediately.
- Fill and drain order: push 16'h1111, 16'h2222, 16'h3333, 16'h4444 -> full=1, ext_ready=0, count=4. Four in_read cycles -> bus_out shows 1111, 2222, 3333, 4444 in order, each in the same cycle as its strobe; then empty=1.
- Wrap-around: push 3, pop 3, push 4, pop 4 (16'hA000+i) -> every word returns in order, count returns to 0, no underflow.
- Simultaneous traffic: with count=2, ext_valid and in_read together for 5 cycles -> count stays 2 and bus_out follows the FIFO order. When full with in_read and ext_valid -> pop only, count goes 4->3.
- Underflow: in_read while empty -> bus_drive=0, bus_out=0, underflow=1 after the edge and held. Pulse clr_err -> underflow=0. clr_err together with a new underflow -> underflow stays 1.
- Reset mid-stream: with count=3, pulse rst -> count=0, empty=1. A following in_read sets underflow and no stale word appears on bus_out.
